// File: rtl/fifo_param_pkg.sv
// Shared constants and helpers for the parametrised FIFO.
package fifo_param_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Ceiling log2 for tools without $clog2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctr.sv
// Modulo-DEPTH pointer with synchronous clear; wraps DEPTH-1 -> 0 explicitly
// so DEPTH does not have to be a power of two.
module fifo_ptr_ctr #(
  parameter int DEPTH = 10,
  parameter int PTR_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  // Clear wins over increment; otherwise advance and wrap at the last entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      if (ptr == PTR_W'(DEPTH - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with optional first-word-fall-through output,
// occupancy count, almost flags, sticky error flags and synchronous flush.
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int DEPTH           = 10,
  parameter int ALMOST_FULL_TH  = 8,
  parameter int ALMOST_EMPTY_TH = 2,
  parameter int FWFT            = FIFO_MODE_STD
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         flush,
  input  logic                         write,
  input  logic [DATA_WIDTH-1:0]        data_In,
  input  logic                         read,
  output logic [DATA_WIDTH-1:0]        data_Out,
  output logic                         isEmpty,
  output logic                         isFull,
  output logic                         almostEmpty,
  output logic                         almostFull,
  output logic [clog2(DEPTH+1)-1:0]    count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      cnt_q;
  logic                  ovf_q;
  logic                  udf_q;

  logic                  active;
  logic                  flush_acc;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  wr_drop;
  logic                  rd_drop;

  // Flush overrides read and write; a full FIFO still accepts a write when a
  // read is accepted on the same edge.
  assign active    = enable & ~flush;
  assign flush_acc = enable & flush;
  assign rd_acc    = active & read & ~isEmpty;
  assign wr_acc    = active & write & (~isFull | rd_acc);
  assign wr_drop   = active & write & ~wr_acc;
  assign rd_drop   = active & read & isEmpty;

  // Flags come only from the registered count, never from read/write.
  assign isEmpty     = (cnt_q == '0);
  assign isFull      = (cnt_q == CNT_W'(DEPTH));
  assign almostEmpty = (cnt_q <= CNT_W'(ALMOST_EMPTY_TH));
  assign almostFull  = (cnt_q >= CNT_W'(ALMOST_FULL_TH));
  assign count       = cnt_q;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;

  fifo_ptr_ctr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_wr_ptr (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (flush_acc),
    .inc     (wr_acc),
    .ptr     (wr_ptr)
  );

  fifo_ptr_ctr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_rd_ptr (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (flush_acc),
    .inc     (rd_acc),
    .ptr     (rd_ptr)
  );

  // Occupancy: simultaneous read and write leave it unchanged.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (flush_acc) begin
      cnt_q <= '0;
    end else if (wr_acc && !rd_acc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (rd_acc && !wr_acc) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Sticky error flags, cleared only by reset or an accepted flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (flush_acc) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr_drop) ovf_q <= 1'b1;
      if (rd_drop) udf_q <= 1'b1;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_In;
    end
  end

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head of queue is presented directly; zero while empty.
      assign data_Out = isEmpty ? '0 : mem[rd_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;

      // Registered read port: loads on an accepted read, holds otherwise
      // (including across flush and rejected reads).
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          dout_q <= '0;
        end else if (rd_acc) begin
          dout_q <= mem[rd_ptr];
        end
      end

      assign data_Out = dout_q;
    end
  endgenerate

endmodule
